// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one request in flight, holds one instruction plus a skid entry for decode.
// Optional macro FETCH_MISALIGN_CHECK_EN adds f_misalign and a MISALIGN state for misaligned redirect targets.
module fetch_stage #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [31:0]     iresp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            f_valid,
  output logic [XLEN-1:0] f_pc,
  output logic [31:0]     f_instr
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            f_misalign
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DISCARD,
    HOLD
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    MISALIGN
`endif
  } state_t;

  state_t          state;
  state_t          redir_state;
  state_t          resume_state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] stale_addr;
  logic [XLEN-1:0] buf_pc;
  logic [31:0]     buf_instr;
  logic            consume;

  assign consume    = f_valid && !stall;
  assign ireq_valid = (state == FETCH) || (state == DISCARD);
  assign ireq_addr  = (state == DISCARD) ? stale_addr : pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic mis_sent;

  assign redir_state  = (redirect_pc[1:0] != 2'b00) ? MISALIGN : FETCH;
  assign resume_state = (pc[1:0] != 2'b00) ? MISALIGN : FETCH;
`else
  assign redir_state  = FETCH;
  assign resume_state = FETCH;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= PC_RESET;
      stale_addr <= PC_RESET;
      buf_pc     <= '0;
      buf_instr  <= '0;
      f_valid    <= 1'b0;
      f_pc       <= '0;
      f_instr    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      f_misalign <= 1'b0;
      mis_sent   <= 1'b0;
`endif
    end else begin
      // Slot empties after a consume unless a branch below refills it.
      if (consume) f_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (consume || redirect_valid) f_misalign <= 1'b0;
      if (redirect_valid) mis_sent <= 1'b0;
`endif
      case (state)
        IDLE: begin
          state <= FETCH;
          if (redirect_valid) begin
            pc      <= redirect_pc;
            f_valid <= 1'b0;
            state   <= redir_state;
          end
        end
        FETCH: begin
          if (redirect_valid) begin
            pc      <= redirect_pc;
            f_valid <= 1'b0;
            if (iresp_data_ok) begin
              state <= redir_state;
            end else begin
              // Bus forbids changing the address of an outstanding request.
              stale_addr <= pc;
              state      <= DISCARD;
            end
          end else if (iresp_data_ok) begin
            pc <= pc + XLEN'(4);
            if (!f_valid || consume) begin
              f_valid <= 1'b1;
              f_pc    <= pc;
              f_instr <= iresp_data;
            end else begin
              buf_pc    <= pc;
              buf_instr <= iresp_data;
              state     <= HOLD;
            end
          end
        end
        DISCARD: begin
          f_valid <= 1'b0;
          if (redirect_valid) begin
            pc <= redirect_pc;
            if (iresp_data_ok) state <= redir_state;
          end else if (iresp_data_ok) begin
            state <= resume_state;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc      <= redirect_pc;
            f_valid <= 1'b0;
            state   <= redir_state;
          end else if (consume) begin
            f_valid <= 1'b1;
            f_pc    <= buf_pc;
            f_instr <= buf_instr;
            state   <= FETCH;
          end
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        MISALIGN: begin
          if (redirect_valid) begin
            pc      <= redirect_pc;
            f_valid <= 1'b0;
            state   <= redir_state;
          end else if (!mis_sent && (!f_valid || consume)) begin
            f_valid    <= 1'b1;
            f_pc       <= pc;
            f_instr    <= NOP;
            f_misalign <= 1'b1;
            mis_sent   <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: bus responder with programmable latency, scoreboard of expected f_* hand-offs, redirect table.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam int unsigned XLEN   = 64;
  localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            iresp_data_ok = 1'b0;
  logic [31:0]     iresp_data = '0;
  logic            stall = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            f_valid;
  logic [XLEN-1:0] f_pc;
  logic [31:0]     f_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            f_misalign;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(XLEN), .PC_RESET(PC_RST)) dut (
    .clk(clk),
    .reset(reset),
    .ireq_valid(ireq_valid),
    .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .f_valid(f_valid),
    .f_pc(f_pc),
    .f_instr(f_instr)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .f_misalign(f_misalign)
`endif
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        mis;
  } sb_t;

  typedef struct {
    int unsigned lat;
    int unsigned delay;
    bit          hold;
    logic [63:0] target;
    logic [63:0] exp_addr;
    logic        exp_fvalid;
  } redir_vec_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  sb_t         sbq[$];
  logic [63:0] cons_q[$];
  bit          pend = 0;
  bit          pend_dead = 0;
  logic [63:0] paddr = '0;
  int unsigned cnt = 0;
  int unsigned lat = 2;
  logic [63:0] exp_next = PC_RST;
  bit          no_req = 0;
  bit          new_req = 0;
  logic [63:0] new_addr = '0;
  bit          prev_hold = 0;
  logic [63:0] hold_pc = '0;
  logic [31:0] hold_instr = '0;
  bit          stall_nxt = 0;
  bit          redir_nxt = 0;
  logic [63:0] redir_tgt = '0;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[17:2]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock: sample outputs just after the edge, then drive this cycle's inputs.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    new_req = 0;
    if (prev_hold) begin
      chk("stall_f_pc_held", f_pc, hold_pc);
      chk("stall_f_instr_held", {32'h0, f_instr}, {32'h0, hold_instr});
    end
    if (pend) begin
      chk("req_valid_held", {63'h0, ireq_valid}, 64'h1);
      chk("req_addr_held", ireq_addr, paddr);
    end
    stall = stall_nxt;
    iresp_data_ok = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        iresp_data_ok = 1'b1;
        iresp_data    = mem(paddr);
        pend          = 0;
        if (!pend_dead) begin
          sbq.push_back('{paddr, mem(paddr), 1'b0});
          exp_next = paddr + 64'd4;
        end
      end
    end else if (ireq_valid) begin
      new_req  = 1;
      new_addr = ireq_addr;
      if (no_req) chk("misalign_no_request", {63'h0, ireq_valid}, 64'h0);
      else chk("req_addr_model", ireq_addr, exp_next);
      pend      = 1;
      pend_dead = 0;
      paddr     = ireq_addr;
      cnt       = lat;
    end
    redirect_valid = redir_nxt;
    redirect_pc    = redir_tgt;
    if (redir_nxt) begin
      sbq.delete();
      if (pend) pend_dead = 1;
      exp_next  = redir_tgt;
      no_req    = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redir_tgt[1:0] != 2'b00) begin
        no_req = 1;
        sbq.push_back('{redir_tgt, NOP, 1'b1});
      end
`endif
      redir_nxt = 0;
    end
    if (!redirect_valid && f_valid && !stall) begin
      chk("sb_nonempty", {63'h0, sbq.size() != 0}, 64'h1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("f_pc", f_pc, e.pc);
        chk("f_instr", {32'h0, f_instr}, {32'h0, e.instr});
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("f_misalign", {63'h0, f_misalign}, {63'h0, e.mis});
`endif
      end
      cons_q.push_back(f_pc);
    end
    prev_hold  = f_valid && stall && !redirect_valid;
    hold_pc    = f_pc;
    hold_instr = f_instr;
  endtask

  task automatic wait_req(input int unsigned budget, output logic [63:0] a);
    int unsigned k = 0;
    do begin
      tick();
      k++;
    end while (!new_req && k < budget);
    chk("req_seen", {63'h0, new_req}, 64'h1);
    a = new_addr;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_ireq_valid", {63'h0, ireq_valid}, 64'h0);
    chk("rst_ireq_addr", ireq_addr, PC_RST);
    chk("rst_f_valid", {63'h0, f_valid}, 64'h0);
    chk("rst_f_pc", f_pc, 64'h0);
    chk("rst_f_instr", {32'h0, f_instr}, 64'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_f_misalign", {63'h0, f_misalign}, 64'h0);
`endif
    pend = 0; pend_dead = 0; iresp_data_ok = 1'b0; stall = 1'b0; stall_nxt = 0;
    redirect_valid = 1'b0; redir_nxt = 0; sbq.delete(); exp_next = PC_RST;
    no_req = 0; prev_hold = 0; new_req = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ireq_valid_held", {63'h0, ireq_valid}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    redir_vec_t  vt[6];
    logic [63:0] a;
    logic [63:0] p0;
    int unsigned k;

    vt[0] = '{4, 1, 1'b0, 64'h0000_0000_8000_1000, 64'h0000_0000_8000_1000, 1'b0};
    vt[1] = '{2, 2, 1'b0, 64'h0000_0000_8000_2000, 64'h0000_0000_8000_2000, 1'b0};
    vt[2] = '{3, 2, 1'b0, 64'h0000_0000_8000_3000, 64'h0000_0000_8000_3000, 1'b0};
    vt[3] = '{1, 1, 1'b0, 64'h0000_0000_8000_4000, 64'h0000_0000_8000_4000, 1'b0};
    vt[4] = '{2, 1, 1'b1, 64'h0000_0000_8000_5000, 64'h0000_0000_8000_5000, 1'b0};
    vt[5] = '{3, 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};

    #2;
    apply_reset();

    // Straight-line fetch, latency 2, no stall.
    lat = 2;
    cons_q.delete();
    wait_req(10, a);
    chk("first_req_addr", a, PC_RST);
    k = 0;
    while (cons_q.size() < 3 && k < 40) begin
      tick();
      k++;
    end
    chk("consumed_three", {63'h0, cons_q.size() >= 3}, 64'h1);
    if (cons_q.size() >= 3) begin
      chk("seq_pc0", cons_q[0], 64'h0000_0000_8000_0000);
      chk("seq_pc1", cons_q[1], 64'h0000_0000_8000_0004);
      chk("seq_pc2", cons_q[2], 64'h0000_0000_8000_0008);
    end

    // Long stall fills the skid entry and parks in HOLD.
    stall_nxt = 1;
    repeat (8) tick();
    chk("hold_ireq_valid", {63'h0, ireq_valid}, 64'h0);
    chk("hold_f_valid", {63'h0, f_valid}, 64'h1);
    p0 = f_pc;
    stall_nxt = 0;
    tick();
    tick();
    chk("hold_release_pc", f_pc, p0 + 64'd4);
    chk("hold_release_valid", {63'h0, f_valid}, 64'h1);
    repeat (6) tick();

    for (int unsigned i = 0; i < 6; i++) begin
      lat = vt[i].lat;
      if (vt[i].hold) begin
        stall_nxt = 1;
        k = 0;
        do begin
          tick();
          k++;
        end while ((ireq_valid || pend) && k < 20);
        chk("tbl_hold_reached", {63'h0, ireq_valid}, 64'h0);
        redir_nxt = 1;
        redir_tgt = vt[i].target;
        tick();
        stall_nxt = 0;
      end else begin
        wait_req(20, a);
        repeat (vt[i].delay - 1) tick();
        redir_nxt = 1;
        redir_tgt = vt[i].target;
        tick();
      end
      tick();
      chk("tbl_f_valid_after_redirect", {63'h0, f_valid}, {63'h0, vt[i].exp_fvalid});
      if (new_req) a = new_addr;
      else wait_req(20, a);
      chk("tbl_next_req_addr", a, vt[i].exp_addr);
      repeat (14) tick();
    end

    // Asynchronous reset while parked in HOLD.
    lat = 2;
    stall_nxt = 1;
    k = 0;
    do begin
      tick();
      k++;
    end while ((ireq_valid || pend) && k < 20);
    chk("pre_reset_hold", {63'h0, ireq_valid}, 64'h0);
    #2;
    apply_reset();
    wait_req(10, a);
    chk("post_reset_req_addr", a, PC_RST);
    repeat (10) tick();

`ifdef FETCH_MISALIGN_CHECK_EN
    redir_nxt = 1;
    redir_tgt = 64'h0000_0000_8000_0002;
    tick();
    k = 0;
    do begin
      tick();
      k++;
    end while (!f_valid && k < 12);
    chk("mis_f_valid", {63'h0, f_valid}, 64'h1);
    chk("mis_f_pc", f_pc, 64'h0000_0000_8000_0002);
    chk("mis_f_instr", {32'h0, f_instr}, {32'h0, NOP});
    chk("mis_flag", {63'h0, f_misalign}, 64'h1);
    repeat (6) tick();
    chk("mis_idle_no_req", {63'h0, ireq_valid}, 64'h0);
    chk("mis_slot_empty", {63'h0, f_valid}, 64'h0);
    redir_nxt = 1;
    redir_tgt = 64'h0000_0000_8000_0100;
    tick();
    wait_req(10, a);
    chk("mis_recover_addr", a, 64'h0000_0000_8000_0100);
    repeat (10) tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
